// File: rtl/exotiny_console_mon.sv
// exotiny_console_mon: snoops console/GPIO bus writes into a FWFT byte FIFO
// and latches sticky pass/fail status on the "DONE" / "ERR" firmware tokens.
module exotiny_console_mon #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNTW  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic                     sel_i,
    input  logic [7:0]               wb_wdat_i,
    output logic                     ch_valid_o,
    output logic [7:0]               ch_data_o,
    input  logic                     ch_ready_i,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     overflow_o,
    output logic [CNTW-1:0]          drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam logic [31:0] TOK_DONE = 32'h444F_4E45;
    localparam logic [23:0] TOK_ERR  = 24'h45_5252;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    logic            stb_q;
    logic [31:0]     sreg_q, sreg_d;
    state_e          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic            ovf_q, ovf_d;
    logic [CNTW-1:0] drop_q, drop_d;
    logic [7:0]      mem_q [DEPTH];

    logic capture_c;
    logic pop_c;
    logic full_c;
    logic push_c;
    logic drop_c;

    // Rising-edge detect on the strobe: one capture per write transaction.
    assign capture_c = wb_stb_i & wb_we_i & sel_i & ~stb_q;
    assign full_c    = (fill_q == FW'(DEPTH));
    assign pop_c     = ch_valid_o & ch_ready_i;
    assign push_c    = capture_c & (~full_c | pop_c);
    assign drop_c    = capture_c & full_c & ~pop_c;

    // Next-state for token tracking, status FSM, FIFO pointers and drop stats.
    always_comb begin
        sreg_d  = sreg_q;
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        fill_d  = fill_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (capture_c) begin
            sreg_d = {sreg_q[23:0], wb_wdat_i};
        end

        case (state_q)
            ST_RUN: begin
                if (capture_c) begin
                    if (sreg_d == TOK_DONE) begin
                        state_d = ST_PASS;
                    end else if (sreg_d[23:0] == TOK_ERR) begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_PASS: state_d = ST_PASS;
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_RUN;
        endcase

        if (push_c) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push_c && !pop_c) begin
            fill_d = fill_q + FW'(1);
        end else if (pop_c && !push_c) begin
            fill_d = fill_q - FW'(1);
        end

        if (drop_c) begin
            ovf_d = 1'b1;
            if (drop_q != {CNTW{1'b1}}) begin
                drop_d = drop_q + CNTW'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stb_q   <= 1'b0;
            sreg_q  <= '0;
            state_q <= ST_RUN;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            stb_q   <= wb_stb_i;
            sreg_q  <= sreg_d;
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fill_q  <= fill_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // FIFO storage; contents need no reset since fill gates visibility.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_c) begin
            mem_q[wptr_q] <= wb_wdat_i;
        end
    end

    assign ch_valid_o = (fill_q != '0);
    assign ch_data_o  = mem_q[rptr_q];
    assign fill_o     = fill_q;
    assign done_o     = (state_q == ST_PASS);
    assign err_o      = (state_q == ST_FAIL);
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_exotiny_console_mon.sv
// Directed bench for exotiny_console_mon built with DEPTH=4, CNTW=2 so that
// overflow and counter saturation are reachable in a few bytes.
module tb_exotiny_console_mon;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNTW  = 2;

    logic       clk;
    logic       rst;
    logic       stb;
    logic       we;
    logic       sel;
    logic [7:0] dat;
    logic       rdy;
    logic       valid;
    logic [7:0] head;
    logic [2:0] fill;
    logic       done;
    logic       err;
    logic       ovf;
    logic [1:0] drop;

    int checks   = 0;
    int failures = 0;

    exotiny_console_mon #(.DEPTH(DEPTH), .CNTW(CNTW)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .sel_i      (sel),
        .wb_wdat_i  (dat),
        .ch_valid_o (valid),
        .ch_data_o  (head),
        .ch_ready_i (rdy),
        .fill_o     (fill),
        .done_o     (done),
        .err_o      (err),
        .overflow_o (ovf),
        .drop_cnt_o (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       stb;
        logic       we;
        logic       sel;
        logic       rdy;
        logic [7:0] dat;
        logic       v;
        logic [2:0] fill;
        logic       dn;
        logic       er;
        logic       ov;
        logic [1:0] drop;
        logic [7:0] head;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic s, input logic w,
                                input logic se, input logic rd, input logic [7:0] d,
                                input logic v, input logic [2:0] f, input logic dn,
                                input logic er, input logic ov, input logic [1:0] dr,
                                input logic [7:0] h);
        vec_t e;
        e.rst = r; e.stb = s; e.we = w; e.sel = se; e.rdy = rd; e.dat = d;
        e.v = v; e.fill = f; e.dn = dn; e.er = er; e.ov = ov; e.drop = dr; e.head = h;
        vq.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic w, input logic se,
                         input logic rd, input logic [7:0] d);
        rst = r; stb = s; we = w; sel = se; rdy = rd; dat = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle write strobe followed by one idle cycle.
    task automatic wr(input logic [7:0] b);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, b);
        @(negedge clk);
        stb = 1'b0; we = 1'b0; sel = 1'b0;
    endtask

    // Pop one byte, checking it is present and equal to the expected value.
    task automatic pop_chk(input string nm, input logic [7:0] exp);
        chk({nm, "_valid"}, 32'(valid), 32'd1);
        chk({nm, "_head"}, 32'(head), 32'(exp));
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset with a strobe present, then "DONE" with idle gaps, then drain.
        add(1,1,1,1,0,8'h44, 0,3'd0,0,0,0,2'd0,8'h00);
        add(0,1,1,1,0,8'h44, 1,3'd1,0,0,0,2'd0,8'h44);
        add(0,0,0,0,0,8'h00, 1,3'd1,0,0,0,2'd0,8'h44);
        add(0,0,0,0,0,8'h00, 1,3'd1,0,0,0,2'd0,8'h44);
        add(0,1,1,1,0,8'h4F, 1,3'd2,0,0,0,2'd0,8'h44);
        add(0,0,0,0,0,8'h00, 1,3'd2,0,0,0,2'd0,8'h44);
        add(0,0,0,0,0,8'h00, 1,3'd2,0,0,0,2'd0,8'h44);
        add(0,1,1,1,0,8'h4E, 1,3'd3,0,0,0,2'd0,8'h44);
        add(0,0,0,0,0,8'h00, 1,3'd3,0,0,0,2'd0,8'h44);
        add(0,0,0,0,0,8'h00, 1,3'd3,0,0,0,2'd0,8'h44);
        add(0,1,1,1,0,8'h45, 1,3'd4,1,0,0,2'd0,8'h44);
        add(0,0,0,0,1,8'h00, 1,3'd3,1,0,0,2'd0,8'h4F);
        add(0,0,0,0,1,8'h00, 1,3'd2,1,0,0,2'd0,8'h4E);
        add(0,0,0,0,1,8'h00, 1,3'd1,1,0,0,2'd0,8'h45);
        add(0,0,0,0,1,8'h00, 0,3'd0,1,0,0,2'd0,8'h00);
        // Read strobe with sel high never captures.
        add(0,1,0,1,0,8'h99, 0,3'd0,1,0,0,2'd0,8'h00);

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].stb, vq[i].we, vq[i].sel, vq[i].rdy, vq[i].dat);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vq[i].v));
            chk($sformatf("vec%0d_fill", i), 32'(fill), 32'(vq[i].fill));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vq[i].dn));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vq[i].er));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vq[i].ov));
            chk($sformatf("vec%0d_drop", i), 32'(drop), 32'(vq[i].drop));
            if (vq[i].v) chk($sformatf("vec%0d_head", i), 32'(head), 32'(vq[i].head));
        end

        // "xERR" then "DONE": FAIL is terminal.
        do_reset();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        wr(8'h78); wr(8'h45); wr(8'h52);
        chk("err_early", 32'(err), 32'd0);
        wr(8'h52);
        chk("err_set", 32'(err), 32'd1);
        chk("err_done0", 32'(done), 32'd0);
        chk("err_fill", 32'(fill), 32'd4);
        wr(8'h44); wr(8'h4F); wr(8'h4E); wr(8'h45);
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_nodone", 32'(done), 32'd0);
        chk("err_ovf", 32'(ovf), 32'd1);
        chk("err_drop_sat", 32'(drop), 32'd3);

        // Write strobe held 5 cycles, then a read strobe: exactly one byte.
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h41);
        repeat (5) @(negedge clk);
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0; sel = 1'b0;
        @(negedge clk);
        chk("hold_fill", 32'(fill), 32'd1);
        pop_chk("hold", 8'h41);
        chk("hold_empty", 32'(valid), 32'd0);

        // Overflow: bytes 1..6 into a 4-deep FIFO.
        do_reset();
        for (int b = 1; b <= 6; b++) wr(8'(b));
        chk("ovf_fill", 32'(fill), 32'd4);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_drop", 32'(drop), 32'd2);
        for (int b = 1; b <= 4; b++) pop_chk($sformatf("ovf_pop%0d", b), 8'(b));
        chk("ovf_empty", 32'(fill), 32'd0);

        // Full FIFO: capture and pop on the same edge, no drop.
        do_reset();
        for (int b = 1; b <= 4; b++) wr(8'(b));
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("fp_fill", 32'(fill), 32'd4);
        chk("fp_drop", 32'(drop), 32'd0);
        chk("fp_ovf", 32'(ovf), 32'd0);
        pop_chk("fp_pop2", 8'h02);
        pop_chk("fp_pop3", 8'h03);
        pop_chk("fp_pop4", 8'h04);
        pop_chk("fp_pop55", 8'h55);
        chk("fp_empty", 32'(valid), 32'd0);

        // Partial token across reset never completes.
        do_reset();
        wr(8'h44); wr(8'h4F); wr(8'h4E);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(8'h45);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_fill", 32'(fill), 32'd1);
        chk("mid_head", 32'(head), 32'h45);

        // Drop counter saturation at 2 bits: 9 bytes -> 5 drops.
        do_reset();
        for (int b = 0; b < 9; b++) wr(8'(8'h60 + b));
        chk("sat_drop", 32'(drop), 32'd3);
        chk("sat_ovf", 32'(ovf), 32'd1);
        chk("sat_fill", 32'(fill), 32'd4);
        pop_chk("sat_head", 8'h60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exotiny_console_mon.md
# exotiny_console_mon

Synthesizable console/test-status monitor for the ExoTiny SoC. It passively snoops CPU data-bus writes to the GPIO/console region and captures one byte per write transaction into a small first-word-fall-through FIFO, which a downstream UART or debug-host drainer empties. It also detects the firmware end-of-test tokens "DONE" and "ERR" and raises sticky pass/fail flags, so riscv-tests and signature runs can report status on silicon and FPGA as well as in simulation.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- CNTW, 16: width of the saturating drop counter.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- wb_stb_i  in  1  CPU data-bus strobe.
- wb_we_i  in  1  CPU data-bus write enable.
- sel_i  in  1  console/GPIO region selected (address decode from the interconnect).
- wb_wdat_i  in  8  write data, bits [7:0] of the bus word.
- ch_valid_o  out  1  FIFO not empty.
- ch_data_o  out  8  head byte; valid while ch_valid_o is high.
- ch_ready_i  in  1  consumer accepts the head byte.
- fill_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
- done_o  out  1  sticky; "DONE" seen.
- err_o  out  1  sticky; "ERR" seen.
- overflow_o  out  1  sticky; at least one byte was dropped.
- drop_cnt_o  out  CNTW  number of dropped bytes; saturates at all-ones.

## Operation
- Capture event: at a clock edge where wb_stb_i & wb_we_i & sel_i is high and registered stb_q is low.
  - stb_q <= wb_stb_i on every edge.
  - A strobe held for N cycles yields exactly one capture.
  - Reads (wb_we_i=0) never capture.
- Shift register sreg[31:0]: on each capture, sreg <= {sreg[23:0], wb_wdat_i}. Dropped bytes are still shifted in.
- Status FSM states:
  - RUN to PASS when the next sreg value equals "DONE" (0x444F4E45).
  - RUN to FAIL when the next sreg[23:0] equals "ERR" (0x455252).
  - Both matches cannot occur on the same byte.
  - PASS and FAIL are terminal until reset; the first match wins.
  - done_o = (state==PASS); err_o = (state==FAIL).
- FIFO:
  - Push happens on a capture.
  - Pop happens when ch_valid_o & ch_ready_i.
  - When full, a push with a simultaneous pop is accepted with no drop; fill_o is unchanged.
  - When full with no pop, the byte is dropped: overflow_o <= 1, drop_cnt_o increments unless already saturated.
  - A pop when empty is impossible because ch_valid_o is low.
  - Read and write pointers wrap modulo DEPTH.
  - ch_data_o is the head entry, read combinationally from the array.
- Capturing continues after PASS or FAIL; the FIFO keeps accepting bytes.

## Timing
- Reset values:
  - stb_q=0, sreg=0, state=RUN, pointers=0.
  - ch_valid_o=0, fill_o=0, done_o=0, err_o=0, overflow_o=0, drop_cnt_o=0.
  - ch_data_o is don't-care while ch_valid_o=0.
- rst_i dominates all other inputs. No capture occurs on an edge where rst_i is high.
- A strobe that is high on the first edge after reset release captures, because stb_q=0.
- Capture at edge t:
  - ch_valid_o and fill_o update after edge t.
  - done_o/err_o are high after edge t when the captured byte completes the token.
- Pop at edge t: the next entry, or ch_valid_o=0, is visible after edge t.
- Empty FIFO with a simultaneous capture: there is no bypass. The byte appears after the edge.
- Reset mid-stream clears sreg. A partial token received before reset never completes a match.

## Test plan
- Write 'D','O','N','E' as separate 1-cycle strobes with 2 idle cycles between them, ch_ready_i=0 -> done_o=1 after the 4th capture edge, err_o=0, fill_o=4. Draining returns 0x44, 0x4F, 0x4E, 0x45 in order.
- Write 'x','E','R','R' -> err_o=1, done_o=0. Then write "DONE" -> done_o stays 0 and err_o stays 1.
- Hold strobe with sel_i=1, we=1, data 0x41 for 5 cycles, then perform one read strobe -> fill_o=1, single byte 0x41.
- DEPTH=4, ch_ready_i=0, write bytes 1..6 -> fill_o=4, overflow_o=1, drop_cnt_o=2. Draining yields 1, 2, 3, 4.
- FIFO full with ch_ready_i=1, capture of 0x55 on the same edge as the pop -> drop_cnt_o unchanged, fill_o stays DEPTH, 0x55 emerges last.
- Write 'D','O','N', assert rst_i for 1 cycle, then write 'E' -> done_o=0, fill_o=1, and the head byte is 0x45. Separately, set CNTW=2 and drop 5 bytes -> drop_cnt_o=3, saturated.
